// File: rtl/dm_ram_hs.sv
// Word-organised data RAM with byte enables behind a valid/ready request/response handshake.
// Clears itself after reset, flags out-of-range addresses and returns data LAT cycles after accept.
module dm_ram_hs #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int LAT    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [DATA_W/8-1:0]   req_be,
   input  logic [31:0]           req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [31:0]           req_pc,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy_init
);
   // state | meaning
   // INIT  | clear sweep, one word per cycle from ptr 0 to DEPTH-1
   // IDLE  | ready for a request, no response pending
   // WAIT  | request accepted, counting down remaining latency
   // RESP  | response presented until rsp_ready

   localparam int          BE_W     = DATA_W / 8;
   localparam int          OFF_W    = (BE_W > 1) ? $clog2(BE_W) : 0;
   localparam int          IDX_W    = $clog2(DEPTH);
   localparam logic [32:0] LIMIT    = 33'(DEPTH * BE_W);
   localparam logic [2:0]  CNT_LOAD = 3'(LAT - 1);

   typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

   state_t            state, state_n;
   logic [IDX_W-1:0]  ptr;
   logic [2:0]        cnt, cnt_n;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              accept;
   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic              unused_pc;

   // Full 32-bit compare, so address bits above the array are still range-checked.
   assign in_range  = {1'b0, req_addr} < LIMIT;
   assign idx       = req_addr[IDX_W+OFF_W-1:OFF_W];
   assign req_ready = (state == IDLE) | ((state == RESP) & rsp_ready);
   assign accept    = req_valid & req_ready;
   assign rsp_valid = (state == RESP);
   assign busy_init = (state == INIT);
   assign unused_pc = ^req_pc;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         INIT: if (ptr == IDX_W'(DEPTH - 1)) state_n = IDLE;
         IDLE: state_n = IDLE;
         WAIT: begin
            if (cnt == 3'd1) state_n = RESP;
            else             cnt_n   = cnt - 3'd1;
         end
         RESP: if (rsp_ready) state_n = IDLE;
         default: state_n = INIT;
      endcase
      if (accept) begin
         if (LAT == 1) begin
            state_n = RESP;
         end else begin
            state_n = WAIT;
            cnt_n   = CNT_LOAD;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= INIT;
         ptr       <= '0;
         cnt       <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (state == INIT) ptr <= ptr + IDX_W'(1);
         if (accept) begin
            rsp_err   <= ~in_range;
            rsp_rdata <= (!req_wen && in_range) ? mem[idx] : '0;
         end
      end
   end

   // Array has no reset; the INIT sweep is what clears it.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[ptr] <= '0;
      end else if (accept && req_wen && in_range) begin
         for (int k = 0; k < BE_W; k++) begin
            if (req_be[k]) mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dm_ram_hs.sv
// Bench for dm_ram_hs: two instances (LAT=3 and LAT=1) checked every cycle against a
// transaction-level model, with literal expectations pinning the model on key reads.
module tb_dm_ram_hs;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset     [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_wen   [2];
   logic [3:0]  req_be    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [31:0] req_pc    [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];
   logic        busy_init [2];

   logic        pin_en  [2];
   logic [31:0] pin_val [2];
   logic        pin_err [2];

   int checks = 0;
   int errors = 0;
   int to_cnt = 0;
   int to_seen = 0;

   dm_ram_hs #(.DATA_W(32), .DEPTH(DEPTH), .LAT(3)) u_lat3 (
      .clk(clk), .reset(reset[0]),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
      .req_be(req_be[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_pc(req_pc[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]), .busy_init(busy_init[0])
   );

   dm_ram_hs #(.DATA_W(32), .DEPTH(DEPTH), .LAT(1)) u_lat1 (
      .clk(clk), .reset(reset[1]),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
      .req_be(req_be[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_pc(req_pc[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]), .busy_init(busy_init[1])
   );

   function automatic int lat_of(input int d);
      return (d == 0) ? 3 : 1;
   endfunction

   // ---------------- model state ----------------
   logic [31:0] m_mem      [2][DEPTH];
   int          m_init     [2];
   bit          m_inflight [2];
   int          m_due      [2];
   logic [31:0] m_rdata    [2];
   bit          m_err      [2];
   bit          m_pin      [2];
   logic [31:0] m_pinv     [2];
   bit          m_pinerr   [2];
   int          busy_run   [2];
   int          cyc = 0;

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, d, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin : cmp
      bit         ev;
      bit         er;
      bit         inr;
      logic [9:0] idx;
      cyc++;
      if (to_cnt != to_seen) begin
         chk("timeout", 0, 32'(to_cnt), 32'(to_seen));
         to_seen = to_cnt;
      end
      for (int d = 0; d < 2; d++) begin
         ev = m_inflight[d] && (cyc >= m_due[d]);
         er = !reset[d] && (m_init[d] == 0) && (!m_inflight[d] || (ev && rsp_ready[d]));
         chk("busy_init", d, 32'(busy_init[d]), 32'((m_init[d] > 0) || reset[d]));
         chk("req_ready", d, 32'(req_ready[d]), 32'(er));
         chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(ev));
         if (reset[d]) begin
            chk("rst_rdata", d, rsp_rdata[d], 32'h0);
            chk("rst_err", d, 32'(rsp_err[d]), 32'h0);
         end
         if (ev) begin
            chk("rsp_rdata", d, rsp_rdata[d], m_rdata[d]);
            chk("rsp_err", d, 32'(rsp_err[d]), 32'(m_err[d]));
            if (m_pin[d] && rsp_ready[d]) begin
               chk("pin_model_rdata", d, m_rdata[d], m_pinv[d]);
               chk("pin_dut_rdata", d, rsp_rdata[d], m_pinv[d]);
               chk("pin_dut_err", d, 32'(rsp_err[d]), 32'(m_pinerr[d]));
            end
         end
         if (reset[d]) begin
            busy_run[d] = 0;
         end else if (busy_init[d]) begin
            busy_run[d]++;
         end else if (busy_run[d] > 0) begin
            chk("init_len", d, 32'(busy_run[d]), 32'(DEPTH));
            busy_run[d] = 0;
         end

         if (reset[d]) begin
            m_init[d]     = DEPTH;
            m_inflight[d] = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[d][i] = 32'h0;
         end else begin
            if (m_init[d] > 0) m_init[d]--;
            if (ev && rsp_ready[d]) m_inflight[d] = 1'b0;
            if (req_valid[d] && er) begin
               idx        = req_addr[d][11:2];
               inr        = req_addr[d] < 32'(DEPTH * 4);
               m_err[d]   = !inr;
               m_rdata[d] = (!req_wen[d] && inr) ? m_mem[d][idx] : 32'h0;
               if (req_wen[d] && inr) begin
                  for (int k = 0; k < 4; k++)
                     if (req_be[d][k]) m_mem[d][idx][8*k +: 8] = req_wdata[d][8*k +: 8];
                  $display("TRACE dut%0d t=%0t pc=%h addr=%h word=%h",
                           d, $time, req_pc[d], req_addr[d], m_mem[d][idx]);
               end
               m_inflight[d] = 1'b1;
               m_due[d]      = cyc + lat_of(d);
               m_pin[d]      = pin_en[d];
               m_pinv[d]     = pin_val[d];
               m_pinerr[d]   = pin_err[d];
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_ready(input int d);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) to_cnt++;
   endtask

   task automatic xact(input int d, input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold, input bit pe, input logic [31:0] pv,
                       input bit perr);
      int n;
      pin_en[d]    = pe;
      pin_val[d]   = pv;
      pin_err[d]   = perr;
      req_wen[d]   = wen;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_be[d]    = be;
      req_pc[d]    = 32'h0000_4000 + addr;
      rsp_ready[d] = (hold == 0);
      req_valid[d] = 1'b1;
      wait_ready(d);
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) to_cnt++;
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         rsp_ready[d] = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   // Back-to-back requests with req_valid held high; optional leading write to base.
   task automatic stream(input int d, input int cnt, input logic [31:0] base, input bit wr_first,
                         input logic [31:0] wdata);
      rsp_ready[d] = 1'b1;
      req_valid[d] = 1'b1;
      for (int i = 0; i < cnt; i++) begin
         req_wen[d]   = wr_first && (i == 0);
         req_be[d]    = 4'hF;
         req_wdata[d] = wdata;
         req_addr[d]  = wr_first ? ((i == 0) ? base : base + 32'(4 * (i - 1))) : base + 32'(4 * i);
         req_pc[d]    = 32'h0000_8000 + 32'(i);
         pin_en[d]    = wr_first && (i == 1);
         pin_val[d]   = wdata;
         pin_err[d]   = 1'b0;
         wait_ready(d);
         @(posedge clk); #1;
      end
      req_valid[d] = 1'b0;
      pin_en[d]    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         reset[d] = 1'b1; req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_be[d] = 4'h0;
         req_addr[d] = 32'h0; req_wdata[d] = 32'h0; req_pc[d] = 32'h0; rsp_ready[d] = 1'b1;
         pin_en[d] = 1'b0; pin_val[d] = 32'h0; pin_err[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      reset[0] = 1'b0;
      reset[1] = 1'b0;
      repeat (DEPTH + 2) @(posedge clk);
      #1;

      for (int d = 0; d < 2; d++) begin
         xact(d, 0, 32'h0000_0000, 32'h0, 4'h0, 0, 1, 32'h0000_0000, 0);
         xact(d, 0, 32'h0000_0FFC, 32'h0, 4'h0, 0, 1, 32'h0000_0000, 0);
         xact(d, 1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 0, 1, 32'h0000_0000, 0);
         xact(d, 0, 32'h0000_0010, 32'h0, 4'h0, 0, 1, 32'hDEADBEEF, 0);
         xact(d, 0, 32'h0000_0013, 32'h0, 4'h0, 0, 1, 32'hDEADBEEF, 0);
         xact(d, 1, 32'h0000_0010, 32'h0123_4567, 4'h0, 0, 1, 32'h0000_0000, 0);
         xact(d, 0, 32'h0000_0010, 32'h0, 4'h0, 0, 1, 32'hDEADBEEF, 0);
         xact(d, 1, 32'h0000_0020, 32'h1122_3344, 4'hF, 0, 0, 32'h0, 0);
         xact(d, 1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 0, 0, 32'h0, 0);
         xact(d, 0, 32'h0000_0020, 32'h0, 4'h0, 0, 1, 32'h11BB_33DD, 0);
         xact(d, 1, 32'h0000_0000, 32'h0C0F_FEE0, 4'hF, 0, 0, 32'h0, 0);
         xact(d, 0, 32'h0000_1000, 32'h0, 4'h0, 0, 1, 32'h0000_0000, 1);
         xact(d, 1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 0, 1, 32'h0000_0000, 1);
         xact(d, 1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 0, 1, 32'h0000_0000, 1);
         xact(d, 0, 32'h0000_0000, 32'h0, 4'h0, 0, 1, 32'h0C0F_FEE0, 0);
         xact(d, 0, 32'h0000_0020, 32'h0, 4'h0, 5, 1, 32'h11BB_33DD, 0);
      end

      stream(1, 6, 32'h0000_0000, 1'b0, 32'h0);
      stream(1, 4, 32'h0000_0030, 1'b1, 32'h5A5A_5A5A);

      // Reset while the LAT=3 instance is in WAIT: the read must never respond.
      xact(0, 1, 32'h0000_0040, 32'h1234_5678, 4'hF, 0, 0, 32'h0, 0);
      pin_en[0] = 1'b0; req_wen[0] = 1'b0; req_addr[0] = 32'h0000_0010;
      rsp_ready[0] = 1'b1; req_valid[0] = 1'b1;
      wait_ready(0);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(posedge clk); #1;
      reset[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset[0] = 1'b0;
      repeat (DEPTH + 2) @(posedge clk);
      #1;
      xact(0, 0, 32'h0000_0040, 32'h0, 4'h0, 0, 1, 32'h0000_0000, 0);
      xact(0, 0, 32'h0000_0010, 32'h0, 4'h0, 0, 1, 32'h0000_0000, 0);

      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
